// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit control slice.
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_ctrl.sv).
package lsu_pkg;

  localparam int XLEN = 64;

  // Width codes match the memory-stage encoding.
  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2,
    W64 = 2'd3
  } lsu_wdt_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input lsu_wdt_e wdt, input logic [2:0] lsb);
    case (wdt)
      W16:     return lsb[0];
      W32:     return |lsb[1:0];
      W64:     return |lsb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and memory-port bundle between the execute stage, the LSU and memory.
// master = execute stage plus memory model, slave = the LSU itself.
interface lsu_if #(parameter int XLEN = lsu_pkg::XLEN);
  import lsu_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // valid never waits on ready, and the LSU holds resp_* stable while resp_valid && !resp_ready.
  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  lsu_wdt_e        req_wdt;
  logic            req_unsigned;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;

  logic            mem_ren;
  logic            mem_wen;
  logic [XLEN-1:0] mem_raddr;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  lsu_wdt_e        mem_wdt;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_wdt, req_unsigned,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wdt
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_wdt, req_unsigned,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wdt
  );

endinterface

// File: rtl/lsu_sext.sv
// Combinational load-data extension: sign or zero extend a right-aligned W8/W16/W32 value.
module lsu_sext #(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  lsu_pkg::lsu_wdt_e wdt,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   din,
  output logic [XLEN-1:0]   dout
);
  import lsu_pkg::*;

  always_comb begin
    dout = din;
    case (wdt)
      W8:  dout = {{(XLEN-8){din[7] & ~is_unsigned}}, din[7:0]};
      W16: dout = {{(XLEN-16){din[15] & ~is_unsigned}}, din[15:0]};
      W32: dout = {{(XLEN-32){din[31] & ~is_unsigned}}, din[31:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control FSM: IDLE -> ISSUE -> (CAPTURE) -> RESP, all outputs registered.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned requests skip memory and respond at once.
module lsu_ctrl #(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic                clk,
  input  logic                rst,
  lsu_if.slave                bus,
  output lsu_pkg::lsu_state_e dbg_state
);
  import lsu_pkg::*;

  lsu_state_e      state;
  logic            uns_q;
  logic            store_q;
  logic            mis;
  logic            trap;
  logic [XLEN-1:0] ext;

  assign mis       = is_misaligned(bus.req_wdt, bus.req_addr[2:0]);
  assign dbg_state = state;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = mis;
`else
  assign trap = 1'b0;
`endif

  // mem_wdt is held from the handshake, so it doubles as the width for extension.
  lsu_sext #(.XLEN(XLEN)) u_sext (
    .wdt        (bus.mem_wdt),
    .is_unsigned(uns_q),
    .din        (bus.mem_rdata),
    .dout       (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      uns_q             <= 1'b0;
      store_q           <= 1'b0;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_misalign <= 1'b0;
      bus.mem_ren       <= 1'b0;
      bus.mem_wen       <= 1'b0;
      bus.mem_raddr     <= '0;
      bus.mem_waddr     <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_wdt       <= W8;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready     <= 1'b0;
            uns_q             <= bus.req_unsigned;
            store_q           <= bus.req_is_store;
            bus.mem_wdt       <= bus.req_wdt;
            bus.resp_misalign <= mis;
            bus.resp_rdata    <= '0;
            if (bus.req_is_store) begin
              bus.mem_waddr <= bus.req_addr;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              bus.mem_raddr <= bus.req_addr;
            end
            if (trap) begin
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
              bus.mem_ren <= ~bus.req_is_store;
              bus.mem_wen <= bus.req_is_store;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.mem_ren <= 1'b0;
          bus.mem_wen <= 1'b0;
          if (store_q) begin
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        // Read data is valid in this cycle, one cycle after mem_ren was sampled.
        CAPTURE: begin
          bus.resp_rdata <= ext;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
